pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch sequencer for the single-issue MIPS datapath.
- Holds the PC and drives the instruction-memory address and request.
- Computes the next PC from PC+4, branch, jump or jump-register redirects, using two instances of the 32-bit `adder`.
- Feeds the decode stage with fetched-PC/valid and counts accepted fetches.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- COUNT_WIDTH, 32, width of fetch_count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard unit holds fetch
- imem_ready  input  1  instruction memory accepts imem_addr this cycle
- redirect_valid  input  1  control-flow change from execute
- redirect_sel  input  2  0=branch, 1=jump, 2=jr, 3=reserved (treated as jr)
- branch_offset  input  32  sign-extended 16-bit immediate (word offset)
- jump_index  input  26  J-type instr_index
- jr_target  input  32  register-sourced target
- imem_req  output  1  fetch request
- imem_addr  output  32  equals pc
- pc  output  32  current PC
- pc_plus4  output  32  pc + 4
- fetch_valid  output  1  imem data this cycle belongs to fetch_pc
- fetch_pc  output  32  address of instruction now returned
- addr_error  output  1  1-cycle pulse: jr_target[1:0] != 0
- fetch_count  output  COUNT_WIDTH  accepted fetches, wraps

Behaviour:
- Reset (sync, has priority over all inputs):
  - Outputs: pc=RESET_VECTOR; fetch_pc=RESET_VECTOR; fetch_valid=0; addr_error=0; fetch_count=0.
  - State: BOOT.
- State BOOT:
  - imem_req=0.
  - Next state: RUN unconditionally.
  - A redirect seen in BOOT is ignored.
- State RUN:
  - imem_req=1; imem_addr=pc.
  - accept = imem_ready & ~stall.
  - Priority per edge is redirect > accept > hold.
  - redirect_valid:
    - pc <= target; fetch_valid <= 0; state <= SQUASH.
    - An in-flight accept is discarded and does not count.
  - accept:
    - pc <= pc_plus4; fetch_pc <= pc; fetch_valid <= 1; fetch_count++.
  - Neither: pc holds; fetch_valid <= 0.
- State SQUASH:
  - imem_req=0; fetch_valid=0. Wrong-path returns are dropped.
  - Next state: RUN.
  - A redirect in SQUASH reloads pc and stays in SQUASH one more cycle.
- Target arithmetic (all modulo 2^32, no overflow flag):
  - branch = pc_plus4 + (branch_offset << 2).
  - jump = {pc_plus4[31:28], jump_index, 2'b00}.
  - jr = {jr_target[31:2], 2'b00}.
  - For jr, addr_error pulses for 1 cycle on the redirect edge when jr_target[1:0] != 0.
- Wrap: pc 32'hFFFF_FFFC + 4 yields 32'h0000_0000 silently.
- Fetch latency: 1 cycle from accept to fetch_valid, matching synchronous-read imem.
- Stall with imem_ready=1: no accept; imem_req stays 1; address stable.
- Reset mid-SQUASH or mid-stall: next cycle is BOOT with all state at reset values.

Decomposition:
- Shared defines header:
  - REDIRECT_BRANCH/JUMP/JR encodings.
  - FSM state encodings BOOT/RUN/SQUASH.
  - WORD_BYTES=4.
- Sub-module: existing `adder`, instantiated twice (pc+4 and branch target).
- Target mux and FSM stay inline.

Test Plan:
- Reset release, imem_ready=1, stall=0 for 4 cycles:
  - Cycle 1 imem_req=0.
  - Then imem_addr 0x0,0x4,0x8.
  - fetch_valid high from cycle 3 with fetch_pc 0x0,0x4.
  - fetch_count=3.
- pc=0x100, branch redirect, branch_offset=32'hFFFF_FFFE:
  - pc becomes 0xFC.
  - Next cycle imem_req=0, fetch_valid=0; then fetch resumes at 0xFC.
- pc=0x8000_0010, jump, jump_index=26'h000_0040:
  - pc=0x8000_0100.
- jr_target=0x0000_2003:
  - pc=0x2000; addr_error pulses exactly 1 cycle.
- stall=1 for 3 cycles at pc=0x20:
  - imem_addr holds 0x20; fetch_valid=0; fetch_count unchanged.
  - Release: accept, pc=0x24.
- Edge cases:
  - Redirect and accept on the same edge: redirect wins; fetch_count unchanged.
  - Reset asserted mid-SQUASH: pc=RESET_VECTOR; BOOT next cycle.
  - pc=0xFFFF_FFFC accept: pc=0x0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings and widths for the PC / instruction-fetch sequencer.
package pc_fetch_unit_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned JIDX_W     = 26;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    REDIRECT_BRANCH = 2'd0,
    REDIRECT_JUMP   = 2'd1,
    REDIRECT_JR     = 2'd2,
    REDIRECT_RSVD   = 2'd3
  } redirect_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

  // J-type target: upper nibble of the delay-slot PC, index, word aligned.
  function automatic logic [ADDR_W-1:0] jump_target(input logic [ADDR_W-1:0] pc4,
                                                    input logic [JIDX_W-1:0] idx);
    return {pc4[ADDR_W-1:ADDR_W-4], idx, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_adder.sv
// Plain modulo-2^WIDTH adder shared by the datapath.
module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, next-PC selection and fetch sequencing for the MIPS front end.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   imem_ready,
  input  logic                   redirect_valid,
  input  logic [1:0]             redirect_sel,
  input  logic [31:0]            branch_offset,
  input  logic [25:0]            jump_index,
  input  logic [31:0]            jr_target,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   fetch_valid,
  output logic [31:0]            fetch_pc,
  output logic                   addr_error,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  fetch_state_e       state;
  logic               accept;
  logic [ADDR_W-1:0]  branch_off_bytes;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  redirect_target;
  logic               jr_misaligned;

  adder #(.WIDTH(ADDR_W)) u_pc_inc (
    .a (pc),
    .b (ADDR_W'(WORD_BYTES)),
    .y (pc_plus4)
  );

  assign branch_off_bytes = branch_offset << 2;

  adder #(.WIDTH(ADDR_W)) u_branch_tgt (
    .a (pc_plus4),
    .b (branch_off_bytes),
    .y (branch_target)
  );

  assign accept    = imem_ready & ~stall;
  assign imem_addr = pc;

  // Redirect target mux; the reserved encoding behaves as jr.
  always_comb begin
    redirect_target = {jr_target[31:2], 2'b00};
    jr_misaligned   = 1'b0;
    unique case (redirect_sel_e'(redirect_sel))
      REDIRECT_BRANCH: redirect_target = branch_target;
      REDIRECT_JUMP:   redirect_target = jump_target(pc_plus4, jump_index);
      default:         jr_misaligned   = |jr_target[1:0];
    endcase
  end

  // Fetch sequencer; a redirect squashes the in-flight fetch for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      fetch_pc    <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      addr_error  <= 1'b0;
      fetch_count <= '0;
      imem_req    <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      addr_error  <= 1'b0;
      unique case (state)
        ST_BOOT: begin
          state    <= ST_RUN;
          imem_req <= 1'b1;
        end
        ST_RUN: begin
          if (redirect_valid) begin
            pc         <= redirect_target;
            addr_error <= jr_misaligned;
            state      <= ST_SQUASH;
            imem_req   <= 1'b0;
          end else if (accept) begin
            pc          <= pc_plus4;
            fetch_pc    <= pc;
            fetch_valid <= 1'b1;
            fetch_count <= fetch_count + COUNT_WIDTH'(1);
          end
        end
        ST_SQUASH: begin
          if (redirect_valid) begin
            pc         <= redirect_target;
            addr_error <= jr_misaligned;
          end else begin
            state    <= ST_RUN;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= ST_BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: reference model plus fetch_pc scoreboard.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] branch_offset, jr_target;
  logic [25:0] jump_index;
  logic        imem_req, fetch_valid, addr_error;
  logic [31:0] imem_addr, pc, pc_plus4, fetch_pc, fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];

  // Reference model state: 0=BOOT 1=RUN 2=SQUASH
  int          m_state;
  logic [31:0] m_pc, m_fpc, m_count;
  logic        m_fv, m_err, m_req;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .COUNT_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .imem_ready     (imem_ready),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .branch_offset  (branch_offset),
    .jump_index     (jump_index),
    .jr_target      (jr_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .addr_error     (addr_error),
    .fetch_count    (fetch_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [1:0] sel, input logic [31:0] off,
                                               input logic [25:0] idx, input logic [31:0] jr,
                                               input logic [31:0] cur_pc);
    logic [31:0] pc4;
    pc4 = cur_pc + 32'd4;
    case (sel)
      2'd0:    return pc4 + (off << 2);
      2'd1:    return {pc4[31:28], idx, 2'b00};
      default: return {jr[31:2], 2'b00};
    endcase
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic st, input logic rdy, input logic rv,
                      input logic [1:0] sel, input logic [31:0] off,
                      input logic [25:0] idx, input logic [31:0] jr);
    logic bad_jr;
    reset = r; stall = st; imem_ready = rdy; redirect_valid = rv;
    redirect_sel = sel; branch_offset = off; jump_index = idx; jr_target = jr;
    bad_jr = sel[1] && (jr[1:0] != 2'b00);
    if (r) begin
      m_state = 0; m_pc = 32'h0; m_fpc = 32'h0; m_fv = 1'b0; m_err = 1'b0; m_count = 32'h0;
      sb_q.delete();
    end else begin
      m_fv = 1'b0; m_err = 1'b0;
      case (m_state)
        0: m_state = 1;
        1: begin
          if (rv) begin
            m_pc = model_target(sel, off, idx, jr, m_pc); m_err = bad_jr; m_state = 2;
          end else if (rdy && !st) begin
            sb_q.push_back(m_pc);
            m_fpc = m_pc; m_pc = m_pc + 32'd4; m_fv = 1'b1; m_count = m_count + 32'd1;
          end
        end
        default: begin
          if (rv) begin
            m_pc = model_target(sel, off, idx, jr, m_pc); m_err = bad_jr;
          end else m_state = 1;
        end
      endcase
    end
    m_req = (m_state == 1);
    @(posedge clk);
    #1;
    check_val("pc", pc, m_pc);
    check_val("imem_addr", imem_addr, m_pc);
    check_val("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_val("imem_req", 32'(imem_req), 32'(m_req));
    check_val("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    check_val("addr_error", 32'(addr_error), 32'(m_err));
    check_val("fetch_count", fetch_count, m_count);
    check_val("fetch_pc_reg", fetch_pc, m_fpc);
    if (fetch_valid) begin
      check_val("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) check_val("sb_fetch_pc", fetch_pc, sb_q.pop_front());
    end
  endtask

  task automatic run(input logic st, input logic rdy);
    step(1'b0, st, rdy, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
  endtask

  task automatic redir(input logic [1:0] sel, input logic [31:0] off,
                       input logic [25:0] idx, input logic [31:0] jr, input logic rdy);
    step(1'b0, 1'b0, rdy, 1'b1, sel, off, idx, jr);
  endtask

  logic [31:0] c0;

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 32'h0, 26'h0, 32'h0000_0040);
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_req", 32'(imem_req), 32'd0);
    check_val("rst_count", fetch_count, 32'd0);

    // Boot then three accepted fetches
    repeat (4) run(1'b0, 1'b1);
    check_val("boot_count", fetch_count, 32'd3);
    check_val("boot_fetch_pc", fetch_pc, 32'h8);

    // jr to 0x100 on the same edge as an accept: redirect wins
    redir(2'd2, 32'h0, 26'h0, 32'h0000_0100, 1'b1);
    check_val("redir_acc_count", fetch_count, 32'd3);
    check_val("redir_acc_pc", pc, 32'h100);
    check_val("squash_req", 32'(imem_req), 32'd0);
    run(1'b0, 1'b0);
    run(1'b0, 1'b0);

    // Backward branch from 0x100
    redir(2'd0, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0);
    check_val("branch_pc", pc, 32'h0000_00FC);
    check_val("branch_squash_fv", 32'(fetch_valid), 32'd0);
    run(1'b0, 1'b0);
    run(1'b0, 1'b1);
    check_val("branch_resume", fetch_pc, 32'h0000_00FC);

    // Jump from 0x8000_0010
    redir(2'd2, 32'h0, 26'h0, 32'h8000_0010, 1'b0);
    run(1'b0, 1'b0);
    redir(2'd1, 32'h0, 26'h000_0040, 32'h0, 1'b0);
    check_val("jump_pc", pc, 32'h8000_0100);
    run(1'b0, 1'b0);

    // Misaligned jr
    redir(2'd2, 32'h0, 26'h0, 32'h0000_2003, 1'b0);
    check_val("jr_pc", pc, 32'h0000_2000);
    check_val("jr_err_on", 32'(addr_error), 32'd1);
    run(1'b0, 1'b0);
    check_val("jr_err_off", 32'(addr_error), 32'd0);

    // Stall with imem_ready high at 0x20
    redir(2'd3, 32'h0, 26'h0, 32'h0000_0020, 1'b0);
    run(1'b0, 1'b0);
    c0 = fetch_count;
    repeat (3) begin
      run(1'b1, 1'b1);
      check_val("stall_addr", imem_addr, 32'h20);
      check_val("stall_count", fetch_count, c0);
      check_val("stall_req", 32'(imem_req), 32'd1);
    end
    run(1'b0, 1'b1);
    check_val("stall_release_pc", pc, 32'h24);

    // PC wrap
    redir(2'd2, 32'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
    run(1'b0, 1'b0);
    run(1'b0, 1'b1);
    check_val("wrap_pc", pc, 32'h0);

    // Redirect while squashing reloads and stays squashed
    redir(2'd2, 32'h0, 26'h0, 32'h0000_0040, 1'b1);
    redir(2'd2, 32'h0, 26'h0, 32'h0000_0080, 1'b1);
    check_val("resquash_pc", pc, 32'h80);
    check_val("resquash_req", 32'(imem_req), 32'd0);
    run(1'b0, 1'b0);
    check_val("resquash_run", 32'(imem_req), 32'd1);

    // Reset mid-squash, then a redirect in BOOT is ignored
    redir(2'd2, 32'h0, 26'h0, 32'h0000_0300, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
    check_val("rst_squash_pc", pc, 32'h0);
    check_val("rst_squash_count", fetch_count, 32'd0);
    redir(2'd2, 32'h0, 26'h0, 32'h0000_0500, 1'b1);
    check_val("boot_redir_pc", pc, 32'h0);
    check_val("boot_redir_req", 32'(imem_req), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 6) == 0, 2'($urandom_range(0, 3)), $urandom, 26'($urandom), $urandom);
    end

    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
